// File: rtl/key_sched_ctrl.sv
// -----------------------------------------------------------------------------
// key_sched_ctrl
//
// Sequencer and storage for the AES-128 key schedule. On an accepted start the
// cipher key is latched and the round index is stepped 0..NR while the
// combinational key_expansion block computes each round key from the previous
// one. Every returned round key is written into an (NR+1)-entry buffer which
// the cipher datapath then reads by index with one cycle of latency.
//
// Optional feature (compile-time macro KEY_CACHE_EN):
//   When defined, a start in DONE whose key equals the latched cipher key is
//   treated as a cache hit: no expansion, state stays DONE, buffer untouched.
//   When undefined, every accepted start runs the full expansion.
//
// Parameters:
//   NR            number of cipher rounds; buffer holds NR+1 keys
//   KW            key / round-key width in bits
//
// Ports:
//   clk_i         system clock, all state on rising edge
//   rst_ni        asynchronous active-low reset
//   start_i       request key expansion; accepted only while ready_o=1
//   ready_o       high in IDLE and DONE, low while expanding
//   key_i         cipher key, sampled in the accept cycle
//   round_o       round index to key_expansion
//   cipher_key_o  latched cipher key to key_expansion
//   prev_key_o    previous round key to key_expansion
//   round_key_i   combinational round key returned by key_expansion
//   keys_valid_o  all NR+1 round keys stored and readable
//   rk_addr_i     round-key read index
//   rk_data_o     registered read data, one cycle after rk_addr_i
// -----------------------------------------------------------------------------
module key_sched_ctrl #(
  parameter int unsigned NR = 10,
  parameter int unsigned KW = 128
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  output logic          ready_o,
  input  logic [KW-1:0] key_i,
  output logic [3:0]    round_o,
  output logic [KW-1:0] cipher_key_o,
  output logic [KW-1:0] prev_key_o,
  input  logic [KW-1:0] round_key_i,
  output logic          keys_valid_o,
  input  logic [3:0]    rk_addr_i,
  output logic [KW-1:0] rk_data_o
);

  localparam logic [3:0] LastRound = 4'(NR);

  typedef enum logic [1:0] {
    StIdle,
    StExpand,
    StDone
  } state_e;

  state_e        state_q;
  logic          ready_q;
  logic          keys_valid_q;
  logic [3:0]    round_q;
  logic [KW-1:0] cipher_key_q;
  logic [KW-1:0] prev_key_q;
  logic [KW-1:0] rk_data_q;

  // Round-key storage; deliberately not reset, reads are gated by keys_valid_q.
  logic [KW-1:0] key_buf_q [0:NR];

  logic          accept;
  logic          rd_ok;
  logic [3:0]    rd_idx;
  logic [KW-1:0] rd_word;

`ifdef KEY_CACHE_EN
  logic cache_hit;

  // Re-requesting the key that is already expanded leaves the buffer as is.
  always_comb begin
    cache_hit = (state_q == StDone) && (key_i == cipher_key_q);
    accept    = start_i && ready_q && !cache_hit;
  end
`else
  always_comb begin
    accept = start_i && ready_q;
  end
`endif

  // Out-of-range or not-yet-valid reads return zero instead of wrapping.
  always_comb begin
    rd_ok   = keys_valid_q && (rk_addr_i <= LastRound);
    rd_idx  = rd_ok ? rk_addr_i : 4'd0;
    rd_word = rd_ok ? key_buf_q[rd_idx] : '0;
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      ready_q      <= 1'b1;
      keys_valid_q <= 1'b0;
      round_q      <= 4'd0;
      cipher_key_q <= '0;
      prev_key_q   <= '0;
      rk_data_q    <= '0;
    end else begin
      rk_data_q <= rd_word;
      unique case (state_q)
        StIdle, StDone: begin
          if (accept) begin
            state_q      <= StExpand;
            ready_q      <= 1'b0;
            keys_valid_q <= 1'b0;
            round_q      <= 4'd0;
            cipher_key_q <= key_i;
            prev_key_q   <= key_i;
          end
        end
        StExpand: begin
          // key_expansion returns the raw key for round 0, so the chain seeds itself.
          prev_key_q <= round_key_i;
          if (round_q == LastRound) begin
            state_q      <= StDone;
            ready_q      <= 1'b1;
            keys_valid_q <= 1'b1;
            round_q      <= 4'd0;
          end else begin
            round_q <= round_q + 4'd1;
          end
        end
        default: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Buffer write: one round key per EXPAND cycle, indexed by the current round.
  always_ff @(posedge clk_i) begin
    if (state_q == StExpand) begin
      key_buf_q[round_q] <= round_key_i;
    end
  end

  assign ready_o      = ready_q;
  assign keys_valid_o = keys_valid_q;
  assign round_o      = round_q;
  assign cipher_key_o = cipher_key_q;
  assign prev_key_o   = prev_key_q;
  assign rk_data_o    = rk_data_q;

endmodule
